// File: rtl/prog_clock_divider.sv
`timescale 1ns/1ps
// prog_clock_divider
// Runtime-programmable integer clock divider. Produces a registered divided
// clock and a one-cycle tick at the start of every output period. A new
// divisor loaded while running is held as pending and only takes effect at
// the next period boundary, so the output never shows runt or glitch pulses.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   en         run enable (0 = stopped, output held low)
//   div_in     requested divisor N (0 and 1 are clamped to 2)
//   div_load   one-cycle strobe capturing div_in
//   clk_out    divided clock, high ceil(N/2) cycles then low floor(N/2)
//   tick       one-cycle pulse in the first high cycle of each period
//   div_active divisor of the period currently being generated
//   busy       a loaded divisor is pending and not yet applied
//   load_err   one-cycle pulse when a divisor below 2 was loaded and clamped
module prog_clock_divider #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_active,
  output logic             busy,
  output logic             load_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(32'd2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] ZERO     = {DIV_W{1'b0}};

  // Divisors below 2 cannot form a high and a low phase; store 2 instead.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    logic [DIV_W-1:0] r;
    if (d < MIN_DIV) begin
      r = MIN_DIV;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_active_q, div_active_d;
  logic [DIV_W-1:0] pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             load_err_q, load_err_d;

  logic [DIV_W-1:0] load_val_s;
  logic             load_bad_s;
  logic [DIV_W:0]   half_s;
  logic [DIV_W:0]   cnt_inc_s;
  logic             period_end_s;

  // Derived values: clamped load value, high-phase length and period end.
  always_comb begin
    load_val_s   = clamp_div(div_in);
    load_bad_s   = (div_in < MIN_DIV);
    // H = ceil(N/2); one extra bit so N = 2^DIV_W-1 does not overflow.
    half_s       = ({1'b0, div_active_q} + {1'b0, ONE}) >> 1;
    cnt_inc_s    = {1'b0, cnt_q} + {1'b0, ONE};
    period_end_s = (cnt_q == (div_active_q - ONE));
  end

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    div_active_d = div_active_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    load_err_d   = div_load & load_bad_s;

    case (state_q)
      IDLE: begin
        cnt_d     = ZERO;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        // While stopped a load is applied directly and supersedes any
        // divisor left pending from the previous run.
        if (div_load) begin
          div_active_d = load_val_s;
          pending_d    = load_val_s;
          busy_d       = 1'b0;
        end else if (en && busy_q) begin
          div_active_d = pending_q;
          busy_d       = 1'b0;
        end else begin
          busy_d = busy_q;
        end
        if (en) begin
          state_d   = RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (!en) begin
          // Intentional stop: the current period may be cut short.
          state_d   = IDLE;
          cnt_d     = ZERO;
          clk_out_d = 1'b0;
          tick_d    = 1'b0;
        end else if (period_end_s) begin
          cnt_d     = ZERO;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          if (busy_q) begin
            div_active_d = pending_q;
            busy_d       = 1'b0;
          end else begin
            div_active_d = div_active_q;
          end
        end else begin
          cnt_d     = cnt_inc_s[DIV_W-1:0];
          clk_out_d = (cnt_inc_s < half_s);
          tick_d    = 1'b0;
        end
        // Placed after the period-start handling so a load on a start edge
        // stays pending for the following period.
        if (div_load) begin
          pending_d = load_val_s;
          busy_d    = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = ZERO;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= ZERO;
      div_active_q <= DEF_DIV;
      pending_q    <= DEF_DIV;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      pending_q    <= pending_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      load_err_q   <= load_err_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign div_active = div_active_q;
  assign busy       = busy_q;
  assign load_err   = load_err_q;

endmodule
